jtag_mem_bridge: RTL and testbench

JTAG_MEM_BRIDGE -- requirements
Module: jtag_mem_bridge

---
 rtl/jtag_mem_bridge.sv | 187 ++++++++++++++++++
 tb/tb_jtag_mem_bridge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_mem_bridge.sv
// JTAG-to-memory bridge: four scan DRs (BYPASS/REG/ADDR/DATA), a small register
// file, and a one-outstanding-request memory master driven by DR updates.
module jtag_mem_bridge #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                         tck,
    input  logic                         aclr,
    input  logic                         tdi,
    input  logic [1:0]                   ir_in,
    input  logic                         v_sdr,
    input  logic                         v_cdr,
    input  logic                         v_udr,
    output logic                         tdo,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_ack,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned REG_W  = 1 + IDX_W + DATA_W;
    localparam int unsigned ADR_W  = 2 + ADDR_W;
    localparam logic [1:0]  IR_BYPASS = 2'b00;
    localparam logic [1:0]  IR_REG    = 2'b01;
    localparam logic [1:0]  IR_ADDR   = 2'b10;
    localparam logic [1:0]  IR_DATA   = 2'b11;

    typedef enum logic {IDLE, REQ} state_t;

    state_t                             state_q, state_d;
    logic                               bypass_dr;
    logic [REG_W-1:0]                   reg_dr;
    logic [ADR_W-1:0]                   addr_dr;
    logic [DATA_W-1:0]                  data_dr;
    logic [NUM_REGS-1:0][DATA_W-1:0]    regfile;
    logic [ADDR_W-1:0]                  ptr_q;
    logic                               inc_en_q;
    logic                               rd_mode_q;
    logic                               ovf_q;
    logic [DATA_W-1:0]                  rd_buf_q;

    logic                               shift_c, capture_c, update_c;
    logic                               busy, launch_req;
    logic                               launch, drop, ack_c, launch_we;
    logic [ADDR_W-1:0]                  launch_addr;
    logic                               reg_wr;
    logic [IDX_W-1:0]                   reg_idx;
    logic [DATA_W-1:0]                  reg_val;
    logic                               adr_inc, adr_rd;
    logic [ADDR_W-1:0]                  adr_addr;

    // Shift beats capture, capture beats update
    assign shift_c   = v_sdr;
    assign capture_c = v_cdr & ~v_sdr;
    assign update_c  = v_udr & ~v_sdr & ~v_cdr;

    assign reg_wr   = reg_dr[REG_W-1];
    assign reg_idx  = reg_dr[DATA_W +: IDX_W];
    assign reg_val  = reg_dr[DATA_W-1:0];
    assign adr_inc  = addr_dr[ADR_W-1];
    assign adr_rd   = addr_dr[ADDR_W];
    assign adr_addr = addr_dr[ADDR_W-1:0];

    assign busy       = (state_q == REQ);
    assign launch_req = update_c & ((ir_in == IR_DATA) | ((ir_in == IR_ADDR) & adr_rd));
    assign reg_q      = regfile;

    always_comb begin
        tdo = 1'b0;
        case (ir_in)
            IR_BYPASS: tdo = bypass_dr;
            IR_REG:    tdo = reg_dr[0];
            IR_ADDR:   tdo = addr_dr[0];
            IR_DATA:   tdo = data_dr[0];
        endcase
    end

    always_ff @(posedge tck or posedge aclr) begin
        if (aclr) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Launch/drop/complete decisions; a launch on the ack edge still counts as busy
    always_comb begin
        state_d     = state_q;
        launch      = 1'b0;
        drop        = 1'b0;
        ack_c       = 1'b0;
        launch_we   = 1'b0;
        launch_addr = ptr_q;
        case (state_q)
            IDLE: begin
                if (launch_req) begin
                    launch      = 1'b1;
                    state_d     = REQ;
                    launch_we   = (ir_in == IR_DATA) & ~rd_mode_q;
                    launch_addr = (ir_in == IR_ADDR) ? adr_addr : ptr_q;
                end
            end
            REQ: begin
                drop = launch_req;
                if (mem_ack) begin
                    ack_c   = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge tck or posedge aclr) begin
        if (aclr) begin
            bypass_dr <= 1'b0;
            reg_dr    <= '0;
            addr_dr   <= '0;
            data_dr   <= '0;
        end else begin
            case (ir_in)
                IR_BYPASS: begin
                    if (shift_c)        bypass_dr <= tdi;
                    else if (capture_c) bypass_dr <= 1'b0;
                end
                IR_REG: begin
                    if (shift_c) reg_dr <= {tdi, reg_dr[REG_W-1:1]};
                    else if (capture_c)
                        reg_dr[DATA_W-1:0] <= (reg_idx == '0) ? DATA_W'({ovf_q, busy})
                                                              : regfile[reg_idx];
                end
                IR_ADDR: begin
                    if (shift_c) addr_dr <= {tdi, addr_dr[ADR_W-1:1]};
                end
                IR_DATA: begin
                    if (shift_c)        data_dr <= {tdi, data_dr[DATA_W-1:1]};
                    else if (capture_c) data_dr <= rd_buf_q;
                end
            endcase
        end
    end

    always_ff @(posedge tck or posedge aclr) begin
        if (aclr) begin
            regfile   <= '0;
            ptr_q     <= '0;
            inc_en_q  <= 1'b0;
            rd_mode_q <= 1'b0;
            ovf_q     <= 1'b0;
            rd_buf_q  <= '0;
        end else begin
            if (update_c && ir_in == IR_REG && reg_wr) begin
                if (reg_idx != '0)   regfile[reg_idx] <= reg_val;
                else if (reg_val[1]) ovf_q <= 1'b0;
            end
            if (drop) ovf_q <= 1'b1;
            if (update_c && ir_in == IR_ADDR && !busy) begin
                ptr_q     <= adr_addr;
                inc_en_q  <= adr_inc;
                rd_mode_q <= adr_rd;
            end
            if (ack_c) begin
                if (inc_en_q) ptr_q <= ptr_q + ADDR_W'(1);
                if (!mem_we)  rd_buf_q <= mem_rdata;
            end
        end
    end

    // Request outputs are frozen from launch until the ack edge
    always_ff @(posedge tck or posedge aclr) begin
        if (aclr) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (launch) begin
            mem_req  <= 1'b1;
            mem_we   <= launch_we;
            mem_addr <= launch_addr;
            if (launch_we) mem_wdata <= data_dr;
        end else if (ack_c) begin
            mem_req <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Bench for jtag_mem_bridge: JTAG driver tasks, a memory responder, and a
// request scoreboard checked by an independent monitor.
module tb_jtag_mem_bridge;

    localparam logic [1:0] IR_BYPASS = 2'b00;
    localparam logic [1:0] IR_REG    = 2'b01;
    localparam logic [1:0] IR_ADDR   = 2'b10;
    localparam logic [1:0] IR_DATA   = 2'b11;
    localparam int ACK_DELAY = 2;

    logic         tck = 1'b0;
    logic         aclr, tdi, v_sdr, v_cdr, v_udr;
    logic [1:0]   ir_in;
    logic         tdo, mem_req, mem_we, mem_ack;
    logic [15:0]  mem_addr;
    logic [7:0]   mem_wdata, mem_rdata;
    logic [127:0] reg_q;

    logic         hold_ack  = 1'b0;
    logic         ack_pulse = 1'b0;
    logic [7:0]   mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;
    req_t exp_q[$];

    jtag_mem_bridge dut (
        .tck(tck), .aclr(aclr), .tdi(tdi), .ir_in(ir_in),
        .v_sdr(v_sdr), .v_cdr(v_cdr), .v_udr(v_udr), .tdo(tdo),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .reg_q(reg_q)
    );

    initial forever #5 tck = ~tck;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata;
        exp_q.push_back(r);
    endtask

    // Memory model: acks ACK_DELAY cycles into a request unless held
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h3C;
        mem[16'h0011] = 8'h4D;
        forever begin
            @(negedge tck);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (ack_pulse) begin
                mem_ack = 1'b1;
                mem_rdata = 8'hEE;
            end else if (mem_req && !hold_ack) begin
                cnt++;
                if (cnt >= ACK_DELAY) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: each new request must match the scoreboard head and hold steady
    initial begin
        logic prev_req;
        req_t cur, e;
        prev_req = 1'b0;
        cur = '0;
        forever begin
            @(negedge tck);
            if (mem_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr %0h we %0b, none expected", mem_addr, mem_we);
                end else begin
                    e = exp_q.pop_front();
                    check("req_we", 32'(mem_we), 32'(e.we));
                    check("req_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) check("req_wdata", 32'(mem_wdata), 32'(e.wdata));
                end
                cur = {mem_we, mem_addr, mem_wdata};
            end else if (mem_req && prev_req) begin
                check("req_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(cur));
            end
            prev_req = mem_req;
        end
    end

    task automatic shift(input logic [1:0] ir, input int n, input logic [31:0] din,
                         output logic [31:0] dout);
        dout = '0;
        ir_in = ir;
        for (int i = 0; i < n; i++) begin
            tdi = din[i];
            v_sdr = 1'b1;
            #1;
            dout[i] = tdo;
            @(negedge tck);
        end
        v_sdr = 1'b0;
        tdi = 1'b0;
    endtask

    task automatic capture(input logic [1:0] ir);
        ir_in = ir; v_cdr = 1'b1;
        @(negedge tck);
        v_cdr = 1'b0;
    endtask

    task automatic update(input logic [1:0] ir);
        ir_in = ir; v_udr = 1'b1;
        @(negedge tck);
        v_udr = 1'b0;
    endtask

    task automatic reg_op(input logic wr, input logic [3:0] idx, input logic [7:0] val);
        logic [31:0] d;
        shift(IR_REG, 13, {19'b0, wr, idx, val}, d);
        update(IR_REG);
    endtask

    task automatic reg_read(input logic [3:0] idx, output logic [7:0] val);
        logic [31:0] d;
        shift(IR_REG, 13, {19'b0, 1'b0, idx, 8'h00}, d);
        capture(IR_REG);
        shift(IR_REG, 13, {19'b0, 1'b0, idx, 8'h00}, d);
        val = d[7:0];
    endtask

    task automatic addr_op(input logic inc, input logic rd, input logic [15:0] a);
        logic [31:0] d;
        shift(IR_ADDR, 18, {14'b0, inc, rd, a}, d);
        update(IR_ADDR);
    endtask

    task automatic data_write(input logic [7:0] v);
        logic [31:0] d;
        shift(IR_DATA, 8, {24'b0, v}, d);
        update(IR_DATA);
    endtask

    task automatic data_read(output logic [7:0] v);
        logic [31:0] d;
        capture(IR_DATA);
        shift(IR_DATA, 8, 32'h0, d);
        v = d[7:0];
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (mem_req && k < 100) begin
            @(negedge tck);
            k++;
        end
        check(name, 32'(mem_req), 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  v;
        aclr = 1'b1; tdi = 1'b0; ir_in = IR_BYPASS;
        v_sdr = 1'b0; v_cdr = 1'b0; v_udr = 1'b0;
        repeat (3) @(negedge tck);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_reg_q_nonzero", 32'(reg_q != '0), 32'h0);
        check("rst_tdo", 32'(tdo), 32'h0);
        aclr = 1'b0;
        @(negedge tck);

        shift(IR_BYPASS, 2, 32'h1, d);
        check("bypass_out", d, 32'h2);

        // Register file write/read-back
        reg_op(1'b1, 4'd3, 8'hA5);
        check("reg_q_3", 32'(reg_q[31:24]), 32'hA5);
        reg_read(4'd3, v);
        check("reg_read_3", 32'(v), 32'hA5);
        reg_op(1'b0, 4'd5, 8'hFF);
        check("reg_q_5_nowrite", 32'(reg_q[47:40]), 32'h0);
        reg_op(1'b1, 4'd15, 8'h3C);
        check("reg_q_15", 32'(reg_q[127:120]), 32'h3C);
        reg_read(4'd0, v);
        check("status_idle", 32'(v), 32'h0);

        // Auto-increment writes across a byte boundary
        addr_op(1'b1, 1'b0, 16'h00FF);
        push_req(1'b1, 16'h00FF, 8'h11);
        data_write(8'h11);
        wait_idle("wr11_done");
        push_req(1'b1, 16'h0100, 8'h22);
        data_write(8'h22);
        wait_idle("wr22_done");
        check("mem_00ff", 32'(mem[16'h00FF]), 32'h11);
        check("mem_0100", 32'(mem[16'h0100]), 32'h22);
        push_req(1'b1, 16'h0101, 8'h33);
        data_write(8'h33);
        wait_idle("wr33_done");

        // Pointer wrap
        addr_op(1'b1, 1'b0, 16'hFFFF);
        push_req(1'b1, 16'hFFFF, 8'h55);
        data_write(8'h55);
        wait_idle("wr55_done");
        push_req(1'b1, 16'h0000, 8'h66);
        data_write(8'h66);
        wait_idle("wr66_done");

        // Prefetching read stream
        push_req(1'b0, 16'h0010, 8'h00);
        addr_op(1'b1, 1'b1, 16'h0010);
        wait_idle("prefetch_done");
        data_read(v);
        check("rd_3c", 32'(v), 32'h3C);
        push_req(1'b0, 16'h0011, 8'h00);
        update(IR_DATA);
        wait_idle("rd11_done");
        data_read(v);
        check("rd_4d", 32'(v), 32'h4D);

        // Overflow on an update while busy, then clear
        addr_op(1'b0, 1'b0, 16'h0200);
        hold_ack = 1'b1;
        push_req(1'b1, 16'h0200, 8'h77);
        data_write(8'h77);
        data_write(8'h88);
        repeat (3) @(negedge tck);
        reg_read(4'd0, v);
        check("status_ovf_busy", 32'(v), 32'h3);
        hold_ack = 1'b0;
        wait_idle("wr77_done");
        check("mem_0200", 32'(mem[16'h0200]), 32'h77);
        reg_read(4'd0, v);
        check("status_ovf", 32'(v), 32'h2);
        reg_op(1'b1, 4'd0, 8'h02);
        reg_read(4'd0, v);
        check("status_cleared", 32'(v), 32'h0);

        // Reset in the middle of a request; a stray ack afterwards is ignored
        addr_op(1'b1, 1'b0, 16'h0300);
        hold_ack = 1'b1;
        push_req(1'b1, 16'h0300, 8'h99);
        data_write(8'h99);
        @(negedge tck);
        aclr = 1'b1;
        #1;
        check("rst_drops_req", 32'(mem_req), 32'h0);
        @(negedge tck);
        aclr = 1'b0;
        hold_ack = 1'b0;
        @(posedge tck);
        ack_pulse = 1'b1;
        @(posedge tck);
        ack_pulse = 1'b0;
        @(negedge tck);
        check("post_rst_req", 32'(mem_req), 32'h0);
        data_read(v);
        check("post_rst_rdbuf", 32'(v), 32'h0);
        check("post_rst_reg_q_nonzero", 32'(reg_q != '0), 32'h0);
        push_req(1'b1, 16'h0000, 8'hAB);
        data_write(8'hAB);
        wait_idle("post_rst_wr_done");

        repeat (5) @(negedge tck);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
